lif_spike_packer: RTL and testbench

LIF_SPIKE_PACKER -- requirements
Module: lif_spike_packer

---
 rtl/lif_spike_packer.sv | 207 ++++++++++++++++++++
 tb/tb_lif_spike_packer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_spike_packer.sv
// LIF spike packer: turns bias-added psum words into per-neuron spike nibbles
// through a one-stage-per-time-step leaky integrate-and-fire pipeline, packs
// UNIT_NUM nibbles per buffer word and flushes a partial word at end of layer.
module lif_spike_packer #(
    parameter int PSUM_W     = 80,
    parameter int TIME_STEPS = 4,
    parameter int P_W        = 20,
    parameter int UNIT_NUM   = 16,
    parameter int VTH        = 1024,
    parameter int DEPTH      = 1152
) (
    input  logic                             s_clk,
    input  logic                             s_rst,
    input  logic [PSUM_W-1:0]                i_PsumData,
    input  logic                             i_PsumValid,
    input  logic                             i_Psum_Finish,
    output logic                             o_wr_en,
    output logic [10:0]                      o_wr_addr,
    output logic [UNIT_NUM*TIME_STEPS-1:0]   o_wr_data,
    output logic                             o_done,
    output logic                             o_err
);

    localparam int MEM_W  = P_W + 2;
    localparam int WORD_W = UNIT_NUM * TIME_STEPS;
    localparam int CNT_W  = (UNIT_NUM > 1) ? $clog2(UNIT_NUM) : 1;
    localparam int ADDR_W = 11;
    localparam logic signed [MEM_W-1:0] VTH_M     = MEM_W'(VTH);
    localparam logic        [CNT_W-1:0] LAST_SLOT = CNT_W'(UNIT_NUM - 1);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_DONE} state_t;

    // Sign-extend one psum field to membrane width.
    function automatic logic signed [MEM_W-1:0] f_sext(input logic [P_W-1:0] f);
        logic signed [P_W-1:0] s;
        s = f;
        return MEM_W'(s);
    endfunction

    // Leaky update (V + X) >>> 1; the sum is formed one bit wider and the
    // top MEM_W bits are kept, which is the flooring arithmetic shift.
    function automatic logic signed [MEM_W-1:0] f_half(input logic signed [MEM_W-1:0] v,
                                                       input logic signed [MEM_W-1:0] x);
        logic signed [MEM_W:0] sum;
        sum = (MEM_W+1)'(v) + (MEM_W+1)'(x);
        return sum[MEM_W:1];
    endfunction

    state_t                    r_state;
    logic [PSUM_W-1:0]         r_data_p0;
    logic                      r_vld_p0;
    logic [WORD_W-1:0]         r_pack;
    logic [CNT_W-1:0]          r_pack_cnt;
    logic                      r_wr_en;
    logic [ADDR_W-1:0]         r_wr_addr;
    logic [WORD_W-1:0]         r_wr_data;
    logic                      r_done;
    logic                      r_err;

    // Per-stage outputs exported from the generate loop, index = stage number.
    logic [TIME_STEPS:1]              w_vld_vec;
    logic [TIME_STEPS-1:0]            w_spk_vec  [1:TIME_STEPS];
    logic signed [MEM_W-1:0]          w_mem_vec  [1:TIME_STEPS];
    logic [PSUM_W-1:0]                w_data_vec [1:TIME_STEPS];

    logic [TIME_STEPS-1:0]     w_nib;
    logic                      w_nib_vld;
    logic                      w_pipe_empty;
    logic [WORD_W-1:0]         w_pack_ins;
    logic [ADDR_W-1:0]         w_addr_next;

    // Stage 0: capture the valid flag; psums arriving in DONE are dropped.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) r_vld_p0 <= 1'b0;
        else       r_vld_p0 <= i_PsumValid && (r_state != ST_DONE);
    end

    // Stage 0: capture the psum word (data only, no reset needed).
    always_ff @(posedge s_clk) begin
        r_data_p0 <= i_PsumData;
    end

    for (genvar k = 1; k <= TIME_STEPS; k++) begin : g_step
        logic signed [MEM_W-1:0]  w_v_in;
        logic signed [MEM_W-1:0]  w_h;
        logic [PSUM_W-1:0]        w_d_in;
        logic                     w_vld_in;
        logic [TIME_STEPS-1:0]    w_spk_in;
        logic                     w_s;
        logic                     r_vld;
        logic [TIME_STEPS-1:0]    r_spk;

        if (k == 1) begin : g_first
            assign w_v_in   = '0;
            assign w_d_in   = r_data_p0;
            assign w_vld_in = r_vld_p0;
            assign w_spk_in = '0;
        end else begin : g_next
            assign w_v_in   = w_mem_vec[k-1];
            assign w_d_in   = w_data_vec[k-1];
            assign w_vld_in = w_vld_vec[k-1];
            assign w_spk_in = w_spk_vec[k-1];
        end

        assign w_h = f_half(w_v_in, f_sext(w_d_in[P_W*(k-1) +: P_W]));
        assign w_s = (w_h >= VTH_M);

        // Stage k: record valid and accumulate spike bit k-1.
        always_ff @(posedge s_clk or posedge s_rst) begin
            if (s_rst) begin
                r_vld <= 1'b0;
                r_spk <= '0;
            end else begin
                r_vld <= w_vld_in;
                r_spk <= w_spk_in | (TIME_STEPS'(w_s) << (k-1));
            end
        end

        assign w_vld_vec[k] = r_vld;
        assign w_spk_vec[k] = r_spk;

        if (k < TIME_STEPS) begin : g_carry
            logic signed [MEM_W-1:0] r_mem;
            logic [PSUM_W-1:0]       r_data;

            // Stage k: membrane resets on a spike, otherwise keeps H.
            always_ff @(posedge s_clk or posedge s_rst) begin
                if (s_rst) r_mem <= '0;
                else       r_mem <= w_s ? '0 : w_h;
            end

            // Stage k: forward the psum word for the later steps.
            always_ff @(posedge s_clk) begin
                r_data <= w_d_in;
            end

            assign w_mem_vec[k]  = r_mem;
            assign w_data_vec[k] = r_data;
        end else begin : g_tail
            assign w_mem_vec[k]  = '0;
            assign w_data_vec[k] = '0;
        end
    end

    assign w_nib        = w_spk_vec[TIME_STEPS];
    assign w_nib_vld    = w_vld_vec[TIME_STEPS];
    assign w_pipe_empty = !(i_PsumValid || r_vld_p0 || (|w_vld_vec));
    assign w_pack_ins   = r_pack | (WORD_W'(w_nib) << (r_pack_cnt * TIME_STEPS));
    assign w_addr_next  = (r_wr_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_wr_addr + 1'b1;

    // Packing, buffer writes and RUN -> FLUSH -> DONE control.
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            r_state    <= ST_RUN;
            r_pack     <= '0;
            r_pack_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (r_wr_en) r_wr_addr <= w_addr_next;
            if (i_PsumValid && (r_state == ST_DONE)) r_err <= 1'b1;
            case (r_state)
                ST_RUN: begin
                    if (w_nib_vld) begin
                        if (r_pack_cnt == LAST_SLOT) begin
                            r_wr_en    <= 1'b1;
                            r_wr_data  <= w_pack_ins;
                            r_pack     <= '0;
                            r_pack_cnt <= '0;
                        end else begin
                            r_pack     <= w_pack_ins;
                            r_pack_cnt <= r_pack_cnt + 1'b1;
                        end
                    end else if (i_Psum_Finish && w_pipe_empty) begin
                        if (r_pack_cnt != '0) begin
                            r_wr_en    <= 1'b1;
                            r_wr_data  <= r_pack;
                            r_pack     <= '0;
                            r_pack_cnt <= '0;
                            r_state    <= ST_FLUSH;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_done    = r_done;
    assign o_err     = r_err;

endmodule

// File: tb/tb_lif_spike_packer.sv
// Bench for lif_spike_packer: a cycle-indexed reference model predicts every
// buffer write (cycle, address, word) plus o_done/o_err timing from the LIF
// equations; a negedge process compares the DUT against it every cycle.
module tb_lif_spike_packer;

    localparam int T     = 4;
    localparam int U     = 16;
    localparam int PW    = 20;
    localparam int PSW   = 80;
    localparam int VTHP  = 1024;
    localparam int DEP   = 4;
    localparam int WW    = U * T;
    localparam int NEVER = 1 << 30;

    logic            s_clk = 1'b0;
    logic            s_rst = 1'b1;
    logic [PSW-1:0]  i_PsumData = '0;
    logic            i_PsumValid = 1'b0;
    logic            i_Psum_Finish = 1'b0;
    logic            o_wr_en;
    logic [10:0]     o_wr_addr;
    logic [WW-1:0]   o_wr_data;
    logic            o_done;
    logic            o_err;

    lif_spike_packer #(
        .PSUM_W(PSW), .TIME_STEPS(T), .P_W(PW), .UNIT_NUM(U), .VTH(VTHP), .DEPTH(DEP)
    ) dut (
        .s_clk(s_clk), .s_rst(s_rst), .i_PsumData(i_PsumData), .i_PsumValid(i_PsumValid),
        .i_Psum_Finish(i_Psum_Finish), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
        .o_wr_data(o_wr_data), .o_done(o_done), .o_err(o_err)
    );

    always #5 s_clk = ~s_clk;

    int cyc = 0;
    always @(posedge s_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    logic [WW-1:0] exp_data [int];
    logic [10:0]   exp_addr [int];
    logic [WW-1:0] m_pack   = '0;
    int            m_cnt    = 0;
    int            m_addr   = 0;
    int            last_vld = -100;
    int            done_cyc = NEVER;
    int            err_cyc  = NEVER;

    localparam logic [PSW-1:0] ALL2048 = {4{20'd2048}};
    localparam logic [PSW-1:0] ALL1024 = {4{20'd1024}};
    localparam logic [PSW-1:0] ALLM4096 = {4{20'hFF000}};
    localparam logic [WW-1:0]  ONES = {WW{1'b1}};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Spike nibble of one neuron, straight from the LIF rules.
    function automatic logic [T-1:0] lif_nibble(input logic [PSW-1:0] d);
        longint v, x, h;
        logic signed [PW-1:0] f;
        logic [T-1:0] s;
        v = 0;
        s = '0;
        for (int t = 0; t < T; t++) begin
            f = d[PW*t +: PW];
            x = longint'(f);
            h = (v + x) >>> 1;
            if (h >= VTHP) begin
                s[t] = 1'b1;
                v = 0;
            end else begin
                v = h;
            end
        end
        return s;
    endfunction

    task automatic model_accept(input int n, input logic [PSW-1:0] d);
        if (n >= done_cyc) begin
            if (n + 1 < err_cyc) err_cyc = n + 1;
            return;
        end
        last_vld = n;
        m_pack = m_pack | (WW'(lif_nibble(d)) << (m_cnt * T));
        m_cnt++;
        if (m_cnt == U) begin
            exp_data[n + T + 2] = m_pack;
            exp_addr[n + T + 2] = 11'(m_addr);
            m_addr = (m_addr + 1) % DEP;
            m_pack = '0;
            m_cnt  = 0;
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic send(input logic [PSW-1:0] d);
        i_PsumData  = d;
        i_PsumValid = 1'b1;
        model_accept(cyc, d);
        tick();
        i_PsumValid = 1'b0;
    endtask

    task automatic do_reset(input int hold);
        s_rst = 1'b1;
        i_PsumValid = 1'b0;
        i_Psum_Finish = 1'b0;
        exp_data.delete();
        exp_addr.delete();
        m_pack = '0; m_cnt = 0; m_addr = 0;
        last_vld = -100; done_cyc = NEVER; err_cyc = NEVER;
        repeat (hold) tick();
        check("rst_wr_data", o_wr_data, 64'h0);
        s_rst = 1'b0;
    endtask

    task automatic finish_req();
        int e;
        i_Psum_Finish = 1'b1;
        e = (last_vld + T + 2 > cyc) ? last_vld + T + 2 : cyc;
        if (m_cnt != 0) begin
            exp_data[e + 1] = m_pack;
            exp_addr[e + 1] = 11'(m_addr);
            m_addr = (m_addr + 1) % DEP;
            m_pack = '0;
            m_cnt  = 0;
            done_cyc = e + 2;
        end else begin
            done_cyc = e + 1;
        end
    endtask

    // Literal expectation for a write at a given cycle.
    task automatic expect_wr(input int c, input logic [10:0] a, input logic [WW-1:0] d, input string nm);
        int g;
        g = 0;
        @(negedge s_clk);
        while (cyc < c && g < 1000) begin
            @(negedge s_clk);
            g++;
        end
        check({nm, "_cycle"}, 64'(cyc), 64'(c));
        check({nm, "_en"}, o_wr_en, 1);
        check({nm, "_addr"}, o_wr_addr, a);
        check({nm, "_data"}, o_wr_data, d);
        tick();
    endtask

    // Per-cycle comparison against the model.
    always @(negedge s_clk) begin
        if (s_rst) begin
            check("rst_wr_en", o_wr_en, 0);
            check("rst_wr_addr", o_wr_addr, 0);
            check("rst_done", o_done, 0);
            check("rst_err", o_err, 0);
        end else begin
            if (exp_data.exists(cyc)) begin
                check("wr_en", o_wr_en, 1);
                check("wr_addr", o_wr_addr, exp_addr[cyc]);
                check("wr_data", o_wr_data, exp_data[cyc]);
            end else begin
                check("wr_en_idle", o_wr_en, 0);
            end
            check("done", o_done, 64'(cyc >= done_cyc));
            check("err", o_err, 64'(cyc >= err_cyc));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected end of test");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        int a;
        logic [PSW-1:0] d;
        logic [PSW-1:0] n0;
        int f;

        tick();
        do_reset(2);

        // All fields 2048: every step spikes.
        a = cyc;
        repeat (U) send(ALL2048);
        expect_wr(a + (U - 1) + T + 2, 11'd0, ONES, "all_spike");

        // All fields 1024: membrane climbs 512..960, never spikes.
        a = cyc;
        repeat (U) send(ALL1024);
        expect_wr(a + (U - 1) + T + 2, 11'd1, '0, "no_spike");

        // Neuron 0 fields {4096, 0, 1024, 2048} -> nibble 1001.
        n0 = {20'd2048, 20'd1024, 20'd0, 20'd4096};
        a = cyc;
        send(n0);
        repeat (U - 1) send('0);
        expect_wr(a + (U - 1) + T + 2, 11'd2, 64'h9, "neuron0_1001");

        // Negative membrane, gapped valids.
        for (int i = 0; i < U; i++) begin
            a = cyc;
            send(ALLM4096);
            tick();
        end
        expect_wr(a + T + 2, 11'd3, '0, "negative");

        // Random psums with random gaps; addresses wrap back to 0.
        for (int i = 0; i < 4 * U; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            for (int t = 0; t < T; t++) begin
                f = int'($urandom_range(0, 12000)) - 6000;
                d[PW*t +: PW] = PW'(f);
            end
            send(d);
        end
        repeat (10) tick();

        // Reset mid-word discards partial and in-flight psums.
        repeat (8) send(ALL2048);
        tick();
        do_reset(2);
        a = cyc;
        repeat (U) send(ALL2048);
        expect_wr(a + (U - 1) + T + 2, 11'd0, ONES, "after_reset");

        // Finish with nothing to flush.
        finish_req();
        repeat (4) tick();
        check("done_noflush", o_done, 1);
        tick();

        // 17 valids then finish: full word, partial flush, done, error.
        do_reset(2);
        a = cyc;
        repeat (U + 1) send(ALL2048);
        finish_req();
        expect_wr(a + (U - 1) + T + 2, 11'd0, ONES, "flush_full");
        expect_wr(a + U + T + 3, 11'd1, 64'hF, "flush_partial");
        @(negedge s_clk);
        check("flush_done", o_done, 1);
        check("flush_err_clear", o_err, 0);
        tick();
        send(ALL2048);
        tick();
        @(negedge s_clk);
        check("err_after_done", o_err, 1);
        check("no_write_after_done", o_wr_en, 0);
        tick();
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
